key_step_conditioner: RTL and testbench



---
 rtl/key_step_pkg.sv | 30 +++
 rtl/key_step_conditioner_debounce.sv | 62 ++++++
 rtl/key_step_conditioner.sv | 157 +++++++++++++++
 tb/tb_key_step_conditioner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_step_pkg.sv
// +--------------------------------------------------------------------+
// | key_step_pkg : shared types and sizing helpers for key stepping    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package key_step_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FIRE    = 2'd1,
      STRETCH = 2'd2,
      HOLD    = 2'd3
   } cond_state_t;

   localparam logic KEY0_VAL = 1'b0;
   localparam logic KEY1_VAL = 1'b1;

   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int STRETCH_CYCLES_DEF  = 250_000;
   localparam int REPEAT_CYCLES_DEF   = 25_000_000;

   // Width of a counter that must hold values 0 .. n-1.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_step_conditioner_debounce.sv
// +--------------------------------------------------------------------+
// | key_debounce : 2-flop synchronizer, polarity normalise, debounce   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module key_debounce
   import key_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic level,
   output logic rise
);

   localparam int             CNT_W    = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // Inverting ahead of the first flop keeps a cleared synchronizer reading "released".
      sync_d  = {sync_q[0], key_raw ^ KEY_ACTIVE_LOW};
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      rise_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

`default_nettype wire

// File: rtl/key_step_conditioner.sv
// +--------------------------------------------------------------------+
// | key_step_conditioner : debounced two-key step strobe / clock pulse |
// | Optional auto-repeat: define KEY_STEP_AUTOREPEAT_EN                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module key_step_conditioner
   import key_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int STRETCH_CYCLES  = STRETCH_CYCLES_DEF,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic CLK_50M,
   input  logic RESET_N,
   input  logic X0,
   input  logic X1,
   output logic STEP,
   output logic BIT_VAL,
   output logic STEP_CLK,
   output logic BUSY
);

   localparam int              ST_W    = cnt_w(STRETCH_CYCLES);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || STRETCH_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("key_step_conditioner: illegal cycle parameter");
   end

   logic lvl0, lvl1, rise0, rise1;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
   ) u_deb0 (
      .clk     (CLK_50M),
      .rst_n   (RESET_N),
      .key_raw (X0),
      .level   (lvl0),
      .rise    (rise0)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
   ) u_deb1 (
      .clk     (CLK_50M),
      .rst_n   (RESET_N),
      .key_raw (X1),
      .level   (lvl1),
      .rise    (rise1)
   );

   cond_state_t     state_q, state_d;
   logic [ST_W-1:0] stretch_cnt_q, stretch_cnt_d;
   logic            bit_val_q, bit_val_d;
   logic            step_q, step_d;
   logic            step_clk_q, step_clk_d;
   logic            busy_q, busy_d;

`ifdef KEY_STEP_AUTOREPEAT_EN
   localparam int              RP_W    = cnt_w(REPEAT_CYCLES);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

   logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [1:0]      keys_q;
`endif

   always_comb begin
      state_d       = state_q;
      stretch_cnt_d = '0;
      bit_val_d     = bit_val_q;
`ifdef KEY_STEP_AUTOREPEAT_EN
      rep_cnt_d     = '0;
`endif
      case (state_q)
         IDLE: begin
            if (rise0 && rise1) begin
               state_d = HOLD;
            end else if (rise0 ^ rise1) begin
               state_d   = FIRE;
               bit_val_d = rise1 ? KEY1_VAL : KEY0_VAL;
            end
         end
         FIRE: state_d = STRETCH;
         STRETCH: begin
            if (stretch_cnt_q == ST_LAST) begin
               state_d = HOLD;
            end else begin
               stretch_cnt_d = stretch_cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!lvl0 && !lvl1) begin
               state_d = IDLE;
`ifdef KEY_STEP_AUTOREPEAT_EN
            end else if ((lvl0 ^ lvl1) && ({lvl1, lvl0} == keys_q)) begin
               // Any change in key levels restarts the repeat interval.
               if (rep_cnt_q == RP_LAST) begin
                  state_d   = FIRE;
                  bit_val_d = lvl1 ? KEY1_VAL : KEY0_VAL;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they cannot glitch.
      step_d     = (state_d == FIRE);
      step_clk_d = (state_d == STRETCH);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge CLK_50M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= IDLE;
         stretch_cnt_q <= '0;
         bit_val_q     <= 1'b0;
         step_q        <= 1'b0;
         step_clk_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         stretch_cnt_q <= stretch_cnt_d;
         bit_val_q     <= bit_val_d;
         step_q        <= step_d;
         step_clk_q    <= step_clk_d;
         busy_q        <= busy_d;
      end
   end

`ifdef KEY_STEP_AUTOREPEAT_EN
   always_ff @(posedge CLK_50M or negedge RESET_N) begin
      if (!RESET_N) begin
         rep_cnt_q <= '0;
         keys_q    <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         keys_q    <= {lvl1, lvl0};
      end
   end
`endif

   assign STEP     = step_q;
   assign BIT_VAL  = bit_val_q;
   assign STEP_CLK = step_clk_q;
   assign BUSY     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_key_step_conditioner.sv
// +--------------------------------------------------------------------+
// | tb_key_step_conditioner : directed bench with STEP scoreboard      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_key_step_conditioner;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic x0    = 1'b1;
   logic x1    = 1'b1;
   logic step, bit_val, step_clk, busy;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   step_cnt = 0;
   int   last_step_cyc = -1;
   bit   exp_q[$];
   bit   allow_repeat = 1'b0;
   int   rep_gap = -1;
   int   rep_steps = 0;
   int   gap;
   bit   exp_bit;

   key_step_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .STRETCH_CYCLES  (3),
      .KEY_ACTIVE_LOW  (1'b1),
      .REPEAT_CYCLES   (8)
   ) dut (
      .CLK_50M  (clk),
      .RESET_N  (rst_n),
      .X0       (x0),
      .X1       (x1),
      .STEP     (step),
      .BIT_VAL  (bit_val),
      .STEP_CLK (step_clk),
      .BUSY     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every STEP consumes one expected BIT_VAL pushed with the stimulus.
   always @(negedge clk) begin
      if (step === 1'b1) begin
         gap = cyc - last_step_cyc;
         step_cnt++;
         last_step_cyc = cyc;
         if (exp_q.size() != 0) begin
            exp_bit = exp_q.pop_front();
            check("sb_bit_val", bit_val, exp_bit);
         end else if (allow_repeat) begin
            rep_steps++;
            check("repeat_bit_val", bit_val, 0);
            if (rep_gap < 0) rep_gap = gap;
            else check("repeat_spacing", gap, rep_gap);
         end else begin
            check("sb_unexpected_step", exp_q.size() + 1, 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_busy_low(input string tag, input int max);
      for (int k = 0; k < max && busy !== 1'b0; k++) tick(1);
      check(tag, busy, 0);
   endtask

   task automatic wait_sb_empty(input string tag, input int max);
      for (int k = 0; k < max && exp_q.size() != 0; k++) tick(1);
      check(tag, exp_q.size(), 0);
   endtask

   task automatic wait_step_clk(input string tag, input int max);
      for (int k = 0; k < max && step_clk !== 1'b1; k++) tick(1);
      check(tag, step_clk, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      #1 rst_n = 1'b0;
      tick(3);
      check("reset_step", step, 0);
      check("reset_bit_val", bit_val, 0);
      check("reset_step_clk", step_clk, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      tick(10);
      check("idle_busy", busy, 0);

      // Single X1 press: cycle-exact latency and stretch window.
      x1 = 1'b0;
      exp_q.push_back(1'b1);
      for (int k = 1; k <= 11; k++) begin
         tick(1);
         check($sformatf("s1_step_e%0d", k), step, (k == 7) ? 1 : 0);
         check($sformatf("s1_step_clk_e%0d", k), step_clk, (k >= 8 && k <= 10) ? 1 : 0);
         if (k == 6) check("s1_busy_e6", busy, 0);
         if (k == 7) begin
            check("s1_bit_val_e7", bit_val, 1);
            check("s1_busy_e7", busy, 1);
         end
      end
      tick(3);
      x1 = 1'b1;
      tick(5);
      check("s1_busy_held", busy, 1);
      wait_busy_low("s1_busy_release", 10);
      wait_sb_empty("s1_sb_empty", 5);

      // Both keys in the same cycle: no step, BIT_VAL keeps 1.
      sc = step_cnt;
      x0 = 1'b0;
      x1 = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick(1);
         check($sformatf("s3_step_clk_e%0d", k), step_clk, 0);
      end
      check("s3_step_count", step_cnt, sc);
      check("s3_busy", busy, 1);
      check("s3_bit_val", bit_val, 1);
      x0 = 1'b1;
      x1 = 1'b1;
      wait_busy_low("s3_busy_release", 15);

      // X0 bounce shorter than the debounce window, then a solid press.
      sc = step_cnt;
      for (int i = 0; i < 5; i++) begin
         x0 = 1'b0;
         tick(2);
         x0 = 1'b1;
         tick(2);
      end
      check("s2_no_step_bounce", step_cnt, sc);
      check("s2_busy_bounce", busy, 0);
      x0 = 1'b0;
      exp_q.push_back(1'b0);
      wait_sb_empty("s2_step", 20);
      check("s2_bit_val", bit_val, 0);
      check("s2_step_count", step_cnt, sc + 1);
      x0 = 1'b1;
      wait_busy_low("s2_busy_release", 20);

      // X1 press, X0 joins during STRETCH: still a single step.
      sc = step_cnt;
      x1 = 1'b0;
      exp_q.push_back(1'b1);
      wait_step_clk("s4_stretch", 20);
      x0 = 1'b0;
      tick(8);
      x0 = 1'b1;
      x1 = 1'b1;
      wait_busy_low("s4_busy_release", 20);
      check("s4_step_count", step_cnt, sc + 1);
      check("s4_bit_val", bit_val, 1);
      wait_sb_empty("s4_sb_empty", 2);

      // Asynchronous reset on the second STEP_CLK-high cycle.
      x1 = 1'b0;
      exp_q.push_back(1'b1);
      wait_step_clk("s5_stretch", 20);
      tick(1);
      check("s5_step_clk_2nd", step_clk, 1);
      #2 rst_n = 1'b0;
      #1;
      check("s5_rst_step_clk", step_clk, 0);
      check("s5_rst_step", step, 0);
      check("s5_rst_bit_val", bit_val, 0);
      check("s5_rst_busy", busy, 0);
      x1 = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(12);
      check("s5_post_busy", busy, 0);
      check("s5_post_step_clk", step_clk, 0);
      x1 = 1'b0;
      exp_q.push_back(1'b1);
      wait_sb_empty("s5_new_step", 20);
      check("s5_new_bit_val", bit_val, 1);
      x1 = 1'b1;
      wait_busy_low("s5_busy_release", 25);

      // X0 held for 40 cycles.
      sc = step_cnt;
      x0 = 1'b0;
      exp_q.push_back(1'b0);
`ifdef KEY_STEP_AUTOREPEAT_EN
      allow_repeat = 1'b1;
`endif
      tick(40);
      x0 = 1'b1;
      wait_busy_low("s6_busy_release", 30);
      allow_repeat = 1'b0;
      wait_sb_empty("s6_sb_empty", 2);
      check("s6_bit_val", bit_val, 0);
`ifdef KEY_STEP_AUTOREPEAT_EN
      check("s6_repeat_seen", (rep_steps >= 2) ? 1 : 0, 1);
`else
      check("s6_single_step", step_cnt, sc + 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
